// File: rtl/gmm_background_select.sv
`timescale 1ns/1ps
// GMM background selection: picks B from sorted weights, then tests the pixel
// against components 0..B-1 with a shared FP32 adder. Includes the adder.
module gmm_fp_adder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  logic [31:0] z_q, z_d;
  logic        stb_q, stb_d;

  // Truncating FP32 add; subnormals flush to zero, exp 255 passes the larger operand through.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [7:0]  eb, es, sh;
    logic [26:0] mb, ms;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic        found;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    eb = big[30:23];
    es = sml[30:23];
    if (eb == 8'hFF) return big;
    if (eb == 8'd0) return 32'd0;
    mb = {1'b1, big[22:0], 3'b000};
    ms = (es == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    sh = eb - es;
    ms = (sh > 8'd26) ? 27'd0 : (ms >> sh);
    if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, ms};
    else sum = {1'b0, mb} - {1'b0, ms};
    if (sum == 28'd0) return 32'd0;
    e = {2'b00, eb};
    if (sum[27]) begin
      sum = sum >> 1;
      e = e + 10'd1;
    end else begin
      lz = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else lz = lz + 5'd1;
        end
      end
      sum = sum << lz;
      e = e - {5'd0, lz};
    end
    if (e[9] || e == 10'd0) return 32'd0;
    if (e >= 10'd255) return {big[31], 8'hFF, 23'd0};
    return {big[31], e[7:0], sum[25:3]};
  endfunction

  always_comb begin
    z_d   = z_q;
    stb_d = stb_q;
    if (stb_q && output_z_ack) begin
      stb_d = 1'b0;
    end else if (!stb_q && input_a_stb && input_b_stb) begin
      z_d   = fp_add(input_a, input_b);
      stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      z_q   <= 32'd0;
      stb_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      stb_q <= stb_d;
    end
  end

  assign output_z     = z_q;
  assign output_z_stb = stb_q;
endmodule

module gmm_background_select #(
  parameter logic [31:0] BG_THRESHOLD = 32'h3F333333
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_bgSelect,
  input  logic [31:0] in_pixel,
  input  logic [31:0] sort_w0,
  input  logic [31:0] sort_w1,
  input  logic [31:0] sort_w2,
  input  logic [31:0] sort_mugrey0,
  input  logic [31:0] sort_mugrey1,
  input  logic [31:0] sort_mugrey2,
  input  logic [31:0] sort_sigma0,
  input  logic [31:0] sort_sigma1,
  input  logic [31:0] sort_sigma2,
  output logic [1:0]  bg_count,
  output logic [1:0]  match_idx,
  output logic        fg_mask,
  output logic        busy,
  output logic        rd_bgSelect,
  output logic [2:0]  dbg_state
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMPW = 3'd1;
  localparam logic [2:0] S_ADDW = 3'd2;
  localparam logic [2:0] S_DIFF = 3'd3;
  localparam logic [2:0] S_KSIG = 3'd4;
  localparam logic [2:0] S_MCHK = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d, w1_q, w1_d, w2_q, w2_d, x_q, x_d;
  logic [31:0] mu0_q, mu0_d, mu1_q, mu1_d, mu2_q, mu2_d;
  logic [31:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [31:0] d_q, d_d, r_q, r_d;
  logic [1:0]  k_q, k_d, j_q, j_d, b_q, b_d;
  logic [1:0]  bg_count_q, bg_count_d, match_idx_q, match_idx_d;
  logic        fg_mask_q, fg_mask_d;

  logic [31:0] add_a, add_b, add_z, mu_j, sig_j, two_sig, half_sig;
  logic        add_stb, add_z_stb;

  // Compare_FP codes: 2'b10 a<b, 2'b01 a>b, 2'b00 equal (+0 == -0).
  function automatic logic [1:0] compare_fp(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 2'b00;
    if (a[31] != b[31]) return a[31] ? 2'b10 : 2'b01;
    if (a[30:0] == b[30:0]) return 2'b00;
    if ((a[30:0] < b[30:0]) != a[31]) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [31:0] sel3(input logic [1:0] i, input logic [31:0] v0,
                                       input logic [31:0] v1, input logic [31:0] v2);
    case (i)
      2'd0:    return v0;
      2'd1:    return v1;
      default: return v2;
    endcase
  endfunction

  assign mu_j  = sel3(j_q, mu0_q, mu1_q, mu2_q);
  assign sig_j = sel3(j_q, s0_q, s1_q, s2_q);

  // 2.5*sigma as 2*sigma + sigma/2, built by exponent edits only.
  always_comb begin
    if (sig_j[30:23] == 8'd0) two_sig = 32'd0;
    else if (sig_j[30:23] >= 8'd254) two_sig = 32'h7F800000;
    else two_sig = {sig_j[31], sig_j[30:23] + 8'd1, sig_j[22:0]};
    if (sig_j[30:23] == 8'd0) half_sig = 32'd0;
    else half_sig = {sig_j[31], sig_j[30:23] - 8'd1, sig_j[22:0]};
  end

  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_stb = 1'b0;
    case (state_q)
      S_ADDW: begin add_a = acc_q; add_b = (k_q == 2'd0) ? w1_q : w2_q; add_stb = 1'b1; end
      S_DIFF: begin add_a = x_q; add_b = {~mu_j[31], mu_j[30:0]}; add_stb = 1'b1; end
      S_KSIG: begin add_a = two_sig; add_b = half_sig; add_stb = 1'b1; end
      default: ;
    endcase
  end

  gmm_fp_adder u_adder (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .input_a     (add_a),
    .input_a_stb (add_stb),
    .input_b     (add_b),
    .input_b_stb (add_stb),
    .output_z    (add_z),
    .output_z_stb(add_z_stb),
    .output_z_ack(1'b1)
  );

  always_comb begin
    state_d = state_q;  acc_d = acc_q;  w1_d = w1_q;  w2_d = w2_q;  x_d = x_q;
    mu0_d = mu0_q;  mu1_d = mu1_q;  mu2_d = mu2_q;
    s0_d = s0_q;  s1_d = s1_q;  s2_d = s2_q;
    d_d = d_q;  r_d = r_q;  k_d = k_q;  j_d = j_q;  b_d = b_q;
    bg_count_d = bg_count_q;  match_idx_d = match_idx_q;  fg_mask_d = fg_mask_q;
    case (state_q)
      S_IDLE: if (en_bgSelect) begin
        acc_d = sort_w0;  w1_d = sort_w1;  w2_d = sort_w2;  x_d = in_pixel;
        mu0_d = sort_mugrey0;  mu1_d = sort_mugrey1;  mu2_d = sort_mugrey2;
        s0_d = sort_sigma0;  s1_d = sort_sigma1;  s2_d = sort_sigma2;
        k_d = 2'd0;
        state_d = S_CMPW;
      end
      S_CMPW: begin
        if (compare_fp(BG_THRESHOLD, acc_q) == 2'b10) begin
          b_d = k_q + 2'd1;  j_d = 2'd0;  state_d = S_DIFF;
        end else if (k_q == 2'd1) begin
          b_d = 2'd3;  j_d = 2'd0;  state_d = S_DIFF;
        end else begin
          state_d = S_ADDW;
        end
      end
      S_ADDW: if (add_z_stb) begin
        acc_d = add_z;  k_d = k_q + 2'd1;  state_d = S_CMPW;
      end
      S_DIFF: if (add_z_stb) begin
        d_d = {1'b0, add_z[30:0]};  state_d = S_KSIG;
      end
      S_KSIG: if (add_z_stb) begin
        r_d = add_z;  state_d = S_MCHK;
      end
      S_MCHK: begin
        if (compare_fp(d_q, r_q) == 2'b10) begin
          match_idx_d = j_q;  fg_mask_d = 1'b0;  bg_count_d = b_q;  state_d = S_DONE;
        end else if ((j_q + 2'd1) < b_q) begin
          j_d = j_q + 2'd1;  state_d = S_DIFF;
        end else begin
          match_idx_d = 2'd3;  fg_mask_d = 1'b1;  bg_count_d = b_q;  state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;  acc_q <= 32'd0;  w1_q <= 32'd0;  w2_q <= 32'd0;  x_q <= 32'd0;
      mu0_q <= 32'd0;  mu1_q <= 32'd0;  mu2_q <= 32'd0;
      s0_q <= 32'd0;  s1_q <= 32'd0;  s2_q <= 32'd0;
      d_q <= 32'd0;  r_q <= 32'd0;  k_q <= 2'd0;  j_q <= 2'd0;  b_q <= 2'd0;
      bg_count_q <= 2'd0;  match_idx_q <= 2'd3;  fg_mask_q <= 1'b0;
    end else begin
      state_q <= state_d;  acc_q <= acc_d;  w1_q <= w1_d;  w2_q <= w2_d;  x_q <= x_d;
      mu0_q <= mu0_d;  mu1_q <= mu1_d;  mu2_q <= mu2_d;
      s0_q <= s0_d;  s1_q <= s1_d;  s2_q <= s2_d;
      d_q <= d_d;  r_q <= r_d;  k_q <= k_d;  j_q <= j_d;  b_q <= b_d;
      bg_count_q <= bg_count_d;  match_idx_q <= match_idx_d;  fg_mask_q <= fg_mask_d;
    end
  end

  assign bg_count    = bg_count_q;
  assign match_idx   = match_idx_q;
  assign fg_mask     = fg_mask_q;
  assign busy        = (state_q != S_IDLE);
  assign rd_bgSelect = (state_q == S_DONE);
  assign dbg_state   = state_q;
endmodule
